// File: rtl/factor_pkg.sv
// Shared definitions for the factoring job controller.
//   state_t      : controller state encoding (also exported on the debug port)
//   STATUS_*     : response status codes
//   SEED_STEP    : amount added to the LFSR seed between machine runs
package factor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_RUN     = 3'd2,
    ST_CHECK   = 3'd3,
    ST_RESPOND = 3'd4
  } state_t;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_BAD_N   = 2'b10;
  localparam logic [1:0] STATUS_ABORT   = 2'b11;

  // Golden-ratio constant: consecutive seeds land far apart in LFSR space.
  localparam logic [31:0] SEED_STEP = 32'h9E3779B9;

endpackage

// File: rtl/factor_check.sv
// Product check for one machine run.
// On i_load the full-width product i_X*i_Y is registered together with the
// verdict "product equals N and neither factor is 1". Both stay held until
// the next load, so the controller reads a stable verdict in its CHECK cycle.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_load            : capture the current machine result
//   i_X, i_Y          : candidate factors (MAX_N_DIGIT/2 bits)
//   i_N               : number being factored (MAX_N_DIGIT bits)
//   o_product         : registered X*Y
//   o_match           : registered success verdict
module factor_check #(
  parameter int MAX_N_DIGIT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_load,
  input  logic [MAX_N_DIGIT/2-1:0]   i_X,
  input  logic [MAX_N_DIGIT/2-1:0]   i_Y,
  input  logic [MAX_N_DIGIT-1:0]     i_N,
  output logic [MAX_N_DIGIT-1:0]     o_product,
  output logic                       o_match
);

  localparam logic [MAX_N_DIGIT/2-1:0] ONE = {{(MAX_N_DIGIT/2-1){1'b0}}, 1'b1};

  logic [MAX_N_DIGIT-1:0] product_w;
  logic                   match_w;
  logic [MAX_N_DIGIT-1:0] product_q;
  logic                   match_q;

  // Two half-width operands: a MAX_N_DIGIT-bit product never overflows.
  assign product_w = MAX_N_DIGIT'(i_X) * MAX_N_DIGIT'(i_Y);
  // A factor of 1 is the trivial factorisation and counts as a failed run.
  assign match_w   = (product_w == i_N) && (i_X != ONE) && (i_Y != ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_q <= '0;
      match_q   <= 1'b0;
    end else if (i_load) begin
      product_q <= product_w;
      match_q   <= match_w;
    end
  end

  assign o_product = product_q;
  assign o_match   = match_q;

endmodule

// File: rtl/factor_job_controller.sv
// Job controller wrapping a sampling-based factoring machine.
// A job (N, seed) is accepted in IDLE, the machine is held in init for
// SETTLE_CYCLES, started, and its result checked; failed runs are retried
// with a stepped seed up to MAX_RETRY runs, then a response is returned.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   i_req_valid/o_req_ready         : request handshake, i_req_N, i_req_seed
//   i_abort                         : cancel the job in SETTLE/RUN/CHECK
//   o_N_MSB/MID/LSB, o_seed         : machine operands, stable for the job
//   o_operation_start               : machine run enable
//   i_operation_end/count, i_X, i_Y: machine result
//   o_rsp_valid/i_rsp_ready         : response handshake with X, Y, status,
//                                     runs and saturating total op count
//   o_dbg_state, o_dbg_product      : controller state and last product
// Handshake rule (both sides): a transfer happens on the rising edge where
// valid and ready are both 1; valid and its payload stay stable until then.
module factor_job_controller
  import factor_pkg::*;
#(
  parameter int MAX_N_DIGIT   = 64,
  parameter int COUNTER_BIT   = 32,
  parameter int MAX_RETRY     = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [MAX_N_DIGIT-1:0]       i_req_N,
  input  logic [31:0]                  i_req_seed,
  input  logic                         i_abort,
  output logic [3:0]                   o_N_MSB,
  output logic [MAX_N_DIGIT/2-3:0]     o_N_MID,
  output logic [MAX_N_DIGIT/2-3:0]     o_N_LSB,
  output logic [31:0]                  o_seed,
  output logic                         o_operation_start,
  input  logic                         i_operation_end,
  input  logic [COUNTER_BIT-1:0]       i_operation_count,
  input  logic [MAX_N_DIGIT/2-1:0]     i_X,
  input  logic [MAX_N_DIGIT/2-1:0]     i_Y,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [MAX_N_DIGIT/2-1:0]     o_rsp_X,
  output logic [MAX_N_DIGIT/2-1:0]     o_rsp_Y,
  output logic [1:0]                   o_rsp_status,
  output logic [2:0]                   o_rsp_runs,
  output logic [COUNTER_BIT+2:0]       o_rsp_total_count,
  output state_t                       o_dbg_state,
  output logic [MAX_N_DIGIT-1:0]       o_dbg_product
);

  localparam int HW = MAX_N_DIGIT / 2;
  localparam int CW = COUNTER_BIT + 3;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRY);

  state_t                 state_q, state_d;
  logic                   alive_q;
  logic [MAX_N_DIGIT-1:0] n_q;
  logic [31:0]            seed_q;
  logic [HW-1:0]          x_q, y_q;
  logic [2:0]             runs_q;
  logic [CW-1:0]          total_q;
  logic [1:0]             status_q;
  logic [SW-1:0]          settle_q;

  logic                   accept_w;
  logic                   bad_n_w;
  logic                   capture_w;
  logic                   match_w;
  logic                   settle_done_w;
  logic                   last_run_w;
  logic [CW:0]            total_sum_w;

  assign accept_w      = (state_q == ST_IDLE) && alive_q && i_req_valid;
  assign bad_n_w       = !i_req_N[0] || (i_req_N < MAX_N_DIGIT'(9));
  // Abort wins over a simultaneous end: the result is not captured.
  assign capture_w     = (state_q == ST_RUN) && i_operation_end && !i_abort;
  assign settle_done_w = (settle_q == SETTLE_LAST);
  assign last_run_w    = (runs_q == RETRY_LIMIT);
  assign total_sum_w   = {1'b0, total_q} + (CW+1)'(i_operation_count);

  factor_check #(
    .MAX_N_DIGIT(MAX_N_DIGIT)
  ) u_check (
    .clk       (clk),
    .rst       (rst),
    .i_load    (capture_w),
    .i_X       (i_X),
    .i_Y       (i_Y),
    .i_N       (n_q),
    .o_product (o_dbg_product),
    .o_match   (match_w)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept_w) state_d = bad_n_w ? ST_RESPOND : ST_SETTLE;
      ST_SETTLE:  if (i_abort) state_d = ST_RESPOND;
                  else if (settle_done_w) state_d = ST_RUN;
      ST_RUN:     if (i_abort) state_d = ST_RESPOND;
                  else if (i_operation_end) state_d = ST_CHECK;
      ST_CHECK:   if (i_abort || match_w || last_run_w) state_d = ST_RESPOND;
                  else state_d = ST_SETTLE;
      ST_RESPOND: if (i_rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_req_ready       = 1'b0;
    o_operation_start = 1'b0;
    o_rsp_valid       = 1'b0;
    unique case (state_q)
      ST_IDLE:    o_req_ready       = alive_q;
      ST_RUN:     o_operation_start = 1'b1;
      ST_RESPOND: o_rsp_valid       = 1'b1;
      default:    ;
    endcase
  end

  // Keeps o_req_ready low during reset and raises it on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alive_q <= 1'b0;
    else     alive_q <= 1'b1;
  end

  // Job datapath: operands, captured result, counters and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q      <= '0;
      seed_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      runs_q   <= '0;
      total_q  <= '0;
      status_q <= STATUS_OK;
      settle_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept_w) begin
          n_q      <= i_req_N;
          seed_q   <= i_req_seed;
          x_q      <= '0;
          y_q      <= '0;
          runs_q   <= '0;
          total_q  <= '0;
          settle_q <= '0;
          status_q <= bad_n_w ? STATUS_BAD_N : STATUS_OK;
        end
        ST_SETTLE: begin
          if (i_abort) status_q <= STATUS_ABORT;
          else if (!settle_done_w) settle_q <= settle_q + 1'b1;
        end
        ST_RUN: begin
          if (i_abort) status_q <= STATUS_ABORT;
          else if (capture_w) begin
            x_q     <= i_X;
            y_q     <= i_Y;
            runs_q  <= runs_q + 1'b1;
            total_q <= total_sum_w[CW] ? '1 : total_sum_w[CW-1:0];
          end
        end
        ST_CHECK: begin
          if (i_abort)         status_q <= STATUS_ABORT;
          else if (match_w)    status_q <= STATUS_OK;
          else if (last_run_w) status_q <= STATUS_TIMEOUT;
          else begin
            seed_q   <= seed_q + SEED_STEP;
            settle_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_N_MSB           = n_q[MAX_N_DIGIT-1 -: 4];
  assign o_N_MID           = n_q[MAX_N_DIGIT-5 -: HW-2];
  assign o_N_LSB           = n_q[HW-3:0];
  assign o_seed            = seed_q;
  assign o_rsp_X           = x_q;
  assign o_rsp_Y           = y_q;
  assign o_rsp_status      = status_q;
  assign o_rsp_runs        = runs_q;
  assign o_rsp_total_count = total_q;
  assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_factor_job_controller.sv
// Bench for factor_job_controller: drives jobs, models the factoring machine
// from driver tasks, and checks responses against an expected queue.
module tb_factor_job_controller;
  import factor_pkg::*;

  localparam int ND = 64;
  localparam int HW = 32;
  localparam int CB = 32;
  localparam int CW = CB + 3;
  localparam int RW = 2 + 3 + CW + HW + HW;
  localparam logic [31:0] STEP = 32'h9E3779B9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            i_req_valid = 1'b0;
  logic            o_req_ready;
  logic [ND-1:0]   i_req_N = '0;
  logic [31:0]     i_req_seed = '0;
  logic            i_abort = 1'b0;
  logic [3:0]      o_N_MSB;
  logic [HW-3:0]   o_N_MID, o_N_LSB;
  logic [31:0]     o_seed;
  logic            o_operation_start;
  logic            i_operation_end = 1'b0;
  logic [CB-1:0]   i_operation_count = '0;
  logic [HW-1:0]   i_X = '0, i_Y = '0;
  logic            o_rsp_valid;
  logic            i_rsp_ready = 1'b0;
  logic [HW-1:0]   o_rsp_X, o_rsp_Y;
  logic [1:0]      o_rsp_status;
  logic [2:0]      o_rsp_runs;
  logic [CW-1:0]   o_rsp_total_count;
  logic [2:0]      o_dbg_state;
  logic [ND-1:0]   o_dbg_product;

  factor_job_controller #(
    .MAX_N_DIGIT(ND), .COUNTER_BIT(CB), .MAX_RETRY(4), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_N(i_req_N), .i_req_seed(i_req_seed), .i_abort(i_abort),
    .o_N_MSB(o_N_MSB), .o_N_MID(o_N_MID), .o_N_LSB(o_N_LSB), .o_seed(o_seed),
    .o_operation_start(o_operation_start), .i_operation_end(i_operation_end),
    .i_operation_count(i_operation_count), .i_X(i_X), .i_Y(i_Y),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_X(o_rsp_X), .o_rsp_Y(o_rsp_Y), .o_rsp_status(o_rsp_status),
    .o_rsp_runs(o_rsp_runs), .o_rsp_total_count(o_rsp_total_count),
    .o_dbg_state(o_dbg_state), .o_dbg_product(o_dbg_product)
  );

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [RW-1:0] pack_rsp(input logic [1:0] st, input logic [2:0] runs,
                                             input logic [CW-1:0] tot,
                                             input logic [HW-1:0] x, input logic [HW-1:0] y);
    return {st, runs, tot, x, y};
  endfunction

  function automatic logic [RW-1:0] cur_rsp();
    return {o_rsp_status, o_rsp_runs, o_rsp_total_count, o_rsp_X, o_rsp_Y};
  endfunction

  // ---------------- driver tasks (all start and end on a negedge) ----------------
  task automatic send_req(input logic [ND-1:0] n, input logic [31:0] seed, output bit to);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (o_req_ready) begin to = 1'b0; break; end
      @(negedge clk);
    end
    if (!to) begin
      i_req_valid = 1'b1; i_req_N = n; i_req_seed = seed;
      @(negedge clk);
      i_req_valid = 1'b0;
    end
  endtask

  task automatic wait_start(output bit to);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (o_operation_start) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic machine_end(input logic [HW-1:0] x, input logic [HW-1:0] y,
                             input logic [CB-1:0] cnt, input int delay);
    repeat (delay) @(negedge clk);
    i_X = x; i_Y = y; i_operation_count = cnt; i_operation_end = 1'b1;
    @(negedge clk);
    i_operation_end = 1'b0;
  endtask

  // Waits for a response, optionally holds i_rsp_ready low for 'hold' cycles
  // while watching stability, then completes the handshake.
  task automatic get_rsp(input int hold, output logic [RW-1:0] got, output bit to,
                         output bit start_seen, output bit unstable);
    to = 1'b1; start_seen = 1'b0; unstable = 1'b0; got = '0;
    for (int i = 0; i < 200; i++) begin
      if (o_operation_start) start_seen = 1'b1;
      if (o_rsp_valid) begin to = 1'b0; break; end
      @(negedge clk);
    end
    if (!to) begin
      got = cur_rsp();
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (o_operation_start) start_seen = 1'b1;
        if (!o_rsp_valid || cur_rsp() !== got || o_req_ready !== 1'b0) unstable = 1'b1;
      end
      i_rsp_ready = 1'b1;
      @(negedge clk);
      i_rsp_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({o_req_ready, o_operation_start, o_rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000", {o_req_ready, o_operation_start, o_rsp_valid});
    end
    n_tests++;
    if ({o_N_MSB, o_N_MID, o_N_LSB, o_seed, cur_rsp()} !== '0) begin
      n_fail++; $display("FAIL reset_data: got N=%h seed=%h rsp=%h want 0",
                         {o_N_MSB, o_N_MID, o_N_LSB}, o_seed, cur_rsp());
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_early: got %b want 0", o_req_ready); end
    @(negedge clk);
    n_tests++;
    if (o_req_ready !== 1'b1 || o_dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_ready_first_edge: got ready=%b state=%0d want 1/0", o_req_ready, o_dbg_state);
    end
  endtask

  task automatic test_ok();
    bit to, ss, un;
    bit [2:0] st;
    logic [RW-1:0] got, exp;
    i_abort = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_abort_ignored: got ready=%b valid=%b want 1/0", o_req_ready, o_rsp_valid);
    end
    i_abort = 1'b0;
    exp_q.push_back(pack_rsp(2'b00, 3'd1, 35'd57, 32'd11, 32'd13));
    send_req(64'd143, 32'h1234_5678, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL ok_req: got no ready want ready"); end
    n_tests++;
    if ({o_N_MSB, o_N_MID, o_N_LSB} !== 64'd143 || o_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL ok_n_outputs: got N=%h ready=%b want 8f/0", {o_N_MSB, o_N_MID, o_N_LSB}, o_req_ready);
    end
    st[2] = o_operation_start; @(negedge clk);
    st[1] = o_operation_start; @(negedge clk);
    st[0] = o_operation_start;
    n_tests++;
    if (st !== 3'b001) begin n_fail++; $display("FAIL ok_settle: got start seq %b want 001", st); end
    n_tests++;
    if (o_seed !== 32'h1234_5678) begin n_fail++; $display("FAIL ok_seed: got %h want 12345678", o_seed); end
    machine_end(32'd11, 32'd13, 32'd57, 3);
    n_tests++;
    if (o_dbg_product !== 64'd143) begin n_fail++; $display("FAIL ok_product: got %0d want 143", o_dbg_product); end
    get_rsp(0, got, to, ss, un);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || got !== exp) begin n_fail++; $display("FAIL ok_rsp: got %h (to=%b) want %h", got, to, exp); end
  endtask

  task automatic test_timeout();
    bit to, ss, un;
    logic [31:0] exp_seed = 32'h7000_0000;
    logic [RW-1:0] got, exp;
    exp_q.push_back(pack_rsp(2'b01, 3'd4, 35'd400, 32'd1, 32'd143));
    send_req(64'd143, exp_seed, to);
    for (int k = 0; k < 4; k++) begin
      wait_start(to);
      n_tests++;
      if (to || o_seed !== exp_seed) begin
        n_fail++; $display("FAIL timeout_seed_run%0d: got %h (to=%b) want %h", k, o_seed, to, exp_seed);
      end
      machine_end(32'd1, 32'd143, 32'd100, $urandom_range(0, 4));
      exp_seed = exp_seed + STEP;
    end
    get_rsp(0, got, to, ss, un);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || got !== exp) begin n_fail++; $display("FAIL timeout_rsp: got %h (to=%b) want %h", got, to, exp); end
  endtask

  task automatic test_bad_n();
    bit to, ss, un;
    logic [ND-1:0] ns [2];
    logic [RW-1:0] got, exp;
    ns[0] = 64'd144; ns[1] = 64'd7;
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(pack_rsp(2'b10, 3'd0, '0, '0, '0));
      send_req(ns[j], $urandom, to);
      n_tests++;
      if (o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bad_n_immediate_%0d: got valid=%b want 1", ns[j], o_rsp_valid); end
      get_rsp(2, got, to, ss, un);
      exp = exp_q.pop_front();
      n_tests++;
      if (to || ss || got !== exp) begin
        n_fail++; $display("FAIL bad_n_rsp_%0d: got %h start=%b (to=%b) want %h start=0", ns[j], got, ss, to, exp);
      end
    end
  endtask

  task automatic test_abort();
    bit to, ss, un;
    logic [RW-1:0] got, exp;
    // j=0: plain abort on RUN cycle 5; j=1: abort coincides with operation end
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(pack_rsp(2'b11, 3'd0, '0, '0, '0));
      send_req(64'd143, $urandom, to);
      wait_start(to);
      repeat (4) @(negedge clk);
      i_abort = 1'b1;
      if (j == 1) begin i_X = 32'd11; i_Y = 32'd13; i_operation_count = 32'd57; i_operation_end = 1'b1; end
      @(negedge clk);
      i_abort = 1'b0; i_operation_end = 1'b0;
      n_tests++;
      if (to || o_operation_start !== 1'b0) begin
        n_fail++; $display("FAIL abort_start_drop_%0d: got %b (to=%b) want 0", j, o_operation_start, to);
      end
      get_rsp(0, got, to, ss, un);
      exp = exp_q.pop_front();
      n_tests++;
      if (to || got !== exp) begin n_fail++; $display("FAIL abort_rsp_%0d: got %h (to=%b) want %h", j, got, to, exp); end
    end
    // Abort in SETTLE after one failed run keeps the captured X/Y and count
    exp_q.push_back(pack_rsp(2'b11, 3'd1, 35'd100, 32'd1, 32'd143));
    send_req(64'd143, $urandom, to);
    wait_start(to);
    machine_end(32'd1, 32'd143, 32'd100, 1);
    @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    get_rsp(0, got, to, ss, un);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || ss || got !== exp) begin
      n_fail++; $display("FAIL abort_settle_rsp: got %h start=%b (to=%b) want %h start=0", got, ss, to, exp);
    end
  endtask

  task automatic test_backpressure();
    bit to, ss, un;
    logic [RW-1:0] got, exp;
    logic [CB-1:0] cnt;
    cnt = CB'($urandom_range(1, 5000));
    exp_q.push_back(pack_rsp(2'b00, 3'd1, CW'(cnt), 32'd13, 32'd17));
    send_req(64'd221, $urandom, to);
    wait_start(to);
    machine_end(32'd13, 32'd17, cnt, $urandom_range(0, 6));
    get_rsp(10, got, to, ss, un);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || un) begin n_fail++; $display("FAIL bp_stable: got unstable=%b (to=%b) want 0", un, to); end
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL bp_rsp: got %h want %h", got, exp); end
    n_tests++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_return_idle: got ready=%b valid=%b want 1/0", o_req_ready, o_rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit to, ss, un, seen;
    logic [RW-1:0] got, exp;
    logic [CB-1:0] cnt;
    send_req(64'd143, 32'hDEAD_BEEF, to);
    wait_start(to);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({o_operation_start, o_rsp_valid, o_req_ready} !== 3'b000 || o_seed !== '0 ||
        {o_N_MSB, o_N_MID, o_N_LSB} !== '0 || o_dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL rst_mid_outputs: got ctl=%b seed=%h N=%h state=%0d want 0",
                         {o_operation_start, o_rsp_valid, o_req_ready}, o_seed, {o_N_MSB, o_N_MID, o_N_LSB}, o_dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_rsp_valid || o_operation_start) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL rst_mid_no_rsp: got activity=1 want 0"); end
    // Next job runs normally
    cnt = CB'($urandom_range(1, 1000));
    exp_q.push_back(pack_rsp(2'b00, 3'd1, CW'(cnt), 32'd13, 32'd11));
    send_req(64'd143, $urandom, to);
    wait_start(to);
    machine_end(32'd13, 32'd11, cnt, 2);
    get_rsp(0, got, to, ss, un);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || got !== exp) begin n_fail++; $display("FAIL rst_mid_next_job: got %h (to=%b) want %h", got, to, exp); end
  endtask

  initial begin
    test_reset();
    test_ok();
    test_timeout();
    test_bad_n();
    test_abort();
    test_backpressure();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/factor_job_controller.md
FACTOR_JOB_CONTROLLER -- requirements
Module: factor_job_controller

Interface
REQ-001 SHALL have parameter MAX_N_DIGIT, default 64: width of N; X and Y are MAX_N_DIGIT/2 bits wide.
REQ-002 SHALL have parameter COUNTER_BIT, default 32: width of the machine's sampling-operation count.
REQ-003 SHALL have parameter MAX_RETRY, default 4: maximum machine runs per job.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2: cycles the machine is held in init with N stable before start.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_req_valid / o_req_ready, in/out, 1 bit each: job request handshake.
REQ-008 SHALL have port i_req_N, input, MAX_N_DIGIT bits: number to factor.
REQ-009 SHALL have port i_req_seed, input, 32 bits: base LFSR seed for the job.
REQ-010 SHALL have port i_abort, input, 1 bit: cancels the job in progress.
REQ-011 SHALL have machine-side outputs o_N_MSB (4 bits), o_N_MID (MAX_N_DIGIT/2-2 bits), o_N_LSB (MAX_N_DIGIT/2-2 bits), o_seed (32 bits) and o_operation_start (1 bit).
REQ-012 SHALL have machine-side inputs i_operation_end (1 bit), i_operation_count (COUNTER_BIT bits), i_X and i_Y (MAX_N_DIGIT/2 bits each).
REQ-013 SHALL have response outputs o_rsp_valid (out) / i_rsp_ready (in), plus o_rsp_X, o_rsp_Y (MAX_N_DIGIT/2 bits), o_rsp_status (2 bits), o_rsp_runs (3 bits) and o_rsp_total_count (COUNTER_BIT+3 bits).

Function
REQ-014 SHALL implement the FSM IDLE -> SETTLE -> RUN -> CHECK -> (SETTLE on retry | RESPOND) -> IDLE.
REQ-015 In IDLE, SHALL assert o_req_ready=1; a job SHALL be accepted on the cycle where i_req_valid and o_req_ready are both 1, latching N and seed.
REQ-016 On accept, if N[0]==0 or N<9, SHALL go directly to RESPOND with status BAD_N=2'b10, X=Y=0, runs=0.
REQ-017 SHALL drive o_N_MSB = N[MAX_N_DIGIT-1 -: 4], o_N_MID = the next MAX_N_DIGIT/2-2 bits and o_N_LSB = the low MAX_N_DIGIT/2-2 bits, held stable from accept until return to IDLE.
REQ-018 In SETTLE, SHALL hold o_operation_start=0 for exactly SETTLE_CYCLES cycles, then enter RUN.
REQ-019 In RUN, SHALL hold o_operation_start=1 until i_operation_end==1 is sampled, then register i_X, i_Y and i_operation_count and enter CHECK.
REQ-020 In CHECK (one cycle), SHALL compute the full-width product i_X*i_Y from the registered values; the run succeeds iff the product equals N and neither factor equals 1.
REQ-021 On success, SHALL go to RESPOND with status OK=2'b00.
REQ-022 On failure, SHALL go to RESPOND with status TIMEOUT=2'b01 if runs==MAX_RETRY; otherwise it SHALL increment runs, set o_seed = o_seed + 32'h9E3779B9 (wrapping) and return to SETTLE.
REQ-023 o_seed SHALL equal i_req_seed for the first run of a job.
REQ-024 o_rsp_total_count SHALL accumulate i_operation_count over all runs of the job, saturating at all-ones.
REQ-025 o_rsp_runs SHALL report the number of completed machine runs, in the range 1..MAX_RETRY (0 for BAD_N and for an abort before any run completes).
REQ-026 If i_abort==1 in SETTLE, RUN or CHECK, SHALL force o_operation_start=0 on the next cycle and go to RESPOND with status ABORT=2'b11 and the last captured X/Y (0 if none).
REQ-027 i_abort SHALL be ignored in IDLE and RESPOND.
REQ-028 In RESPOND, SHALL hold o_rsp_valid=1 with all response fields stable until i_rsp_ready==1, then return to IDLE on the next cycle.
REQ-029 o_req_ready SHALL be 0 in every state except IDLE.
REQ-030 If i_operation_end and i_abort are asserted in the same cycle, abort SHALL take priority.

Reset
REQ-031 While rst=1, SHALL enter IDLE asynchronously.
REQ-032 While rst=1, SHALL drive o_operation_start=0, o_rsp_valid=0, o_req_ready=0 and all data/count/seed outputs to 0.
REQ-033 After rst deasserts, o_req_ready=1 SHALL appear on the first clock edge.
REQ-034 A reset mid-job SHALL discard the job with no response.

Structure
REQ-035 The state encoding, the status codes (OK, TIMEOUT, BAD_N, ABORT) and the seed increment constant SHALL live in a shared package, factor_pkg.
REQ-036 The product check SHALL be a sub-module, factor_check, that registers the X*Y product and the compare result.
REQ-037 The state machine and all counters SHALL be in factor_job_controller.

Verification
REQ-038 The bench SHALL cover: N=143, machine model ends with X=11, Y=13, count=57 -> status 00, runs 1, total 57.
REQ-039 The bench SHALL cover: N=143, model returns X=1, Y=143 four times, 100 ops each -> status 01, runs 4, total 400, o_seed stepped by 9E3779B9 per run.
REQ-040 The bench SHALL cover: N=144, and separately N=7 -> immediate status 10, o_operation_start never asserted.
REQ-041 The bench SHALL cover: i_abort in RUN on cycle 5 -> o_operation_start=0 next cycle, status 11.
REQ-042 The bench SHALL cover: i_rsp_ready held low 10 cycles -> response stable, o_req_ready=0 throughout.
REQ-043 The bench SHALL cover: rst pulsed during RUN -> outputs 0 immediately, no response, next job accepted normally.
